// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: valid/ready byte input, back-to-back 8N1 frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits, giving 8E1 frames.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           baud_div,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   fifo_count
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic                LAST_STOP = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                  state, next_state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic                    push, pop;
    logic                    fifo_nonempty;
    logic [15:0]             baud_cnt, bdiv_q;
    logic [2:0]              bit_cnt;
    logic                    stop_cnt;
    logic [7:0]              shreg;
    logic                    tx_d;
    logic                    bit_done, last_data, last_stop;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign wr_ready      = (fifo_count != FULL);
    assign push          = wr_valid && wr_ready;
    assign fifo_nonempty = (fifo_count != '0);

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (DEPTH_LOG2 + 1)'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    assign bit_done  = (baud_cnt == bdiv_q);
    assign last_data = (bit_cnt == 3'd7);
    assign last_stop = (stop_cnt == LAST_STOP);
    assign tx_busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (fifo_nonempty) next_state = S_START;
            S_START:  if (bit_done) next_state = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (bit_done && last_data) next_state = S_PARITY;
            S_PARITY: if (bit_done) next_state = S_STOP;
`else
            S_DATA:   if (bit_done && last_data) next_state = S_STOP;
`endif
            S_STOP:   if (bit_done && last_stop) next_state = fifo_nonempty ? S_START : S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        pop  = 1'b0;
        tx_d = tx;
        unique case (state)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    pop  = 1'b1;
                    tx_d = 1'b0;
                end
            end
            S_START: if (bit_done) tx_d = shreg[0];
            S_DATA: begin
                if (bit_done) begin
`ifdef UART_TX_PARITY_EN
                    tx_d = last_data ? parity_q : shreg[1];
`else
                    tx_d = last_data ? 1'b1 : shreg[1];
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_done) tx_d = 1'b1;
`endif
            S_STOP: begin
                // Final stop edge chains straight into the next start bit when data is waiting.
                if (bit_done && last_stop && fifo_nonempty) begin
                    pop  = 1'b1;
                    tx_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bdiv_q   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx <= tx_d;
            if (pop) begin
                shreg    <= mem[rd_ptr];
                bdiv_q   <= baud_div;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^mem[rd_ptr];
`endif
            end else begin
                baud_cnt <= (state == S_IDLE || bit_done) ? 16'd0 : baud_cnt + 16'd1;
                if (state == S_DATA && bit_done) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == S_STOP && bit_done)
                    stop_cnt <= ~stop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven single frames plus burst, full-FIFO and reset sequences.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
        logic       par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } sb_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [15:0]         baud_div;
    logic [7:0]          wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic                tx;
    logic                tx_busy;
    logic [DEPTH_LOG2:0] fifo_count;

    int  checks = 0;
    int  errors = 0;
    sb_t sb_q[$];
    vec_t vecs [7];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected line pattern, index 0 transmitted first: start, d0..d7, [parity], stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0} & {1'b0, 10'h3ff} | (11'(p) & 11'h0);
`endif
    endfunction

    // Called at a negedge; pushes to the scoreboard when the byte will be accepted.
    task automatic drive_write(input logic [7:0] d, input logic p);
        sb_t e;
        wr_data  = d;
        wr_valid = 1'b1;
        if (wr_ready) begin
            e.data = d;
            e.par  = p;
            sb_q.push_back(e);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at the negedge showing the first clock of a start bit; returns at the negedge after the frame.
    task automatic receive_frame(input int div, input string name);
        logic [10:0] rx;
        bit          stable;
        sb_t         e;
        rx     = '0;
        stable = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            rx[b] = tx;
            for (int c = 0; c <= div; c++) begin
                if (tx !== rx[b]) stable = 1'b0;
                @(negedge clk);
            end
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: frame 0x%0h seen with empty scoreboard", name, rx);
        end else begin
            e = sb_q.pop_front();
            check({name, " frame"}, rx, make_frame(e.data, e.par));
        end
        check({name, " bit stable"}, stable, 1);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int accepted;
        int n;

        vecs[0] = '{8'h55, 3, 1'b0};
        vecs[1] = '{8'hA3, 0, 1'b0};
        vecs[2] = '{8'h00, 1, 1'b0};
        vecs[3] = '{8'hFF, 2, 1'b0};
        vecs[4] = '{8'h07, 3, 1'b1};
        vecs[5] = '{8'h03, 3, 1'b0};
        vecs[6] = '{8'h80, 5, 1'b1};

        rst      = 1'b1;
        baud_div = 16'd3;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        #2;
        check("reset tx", tx, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0 || wr_ready !== 1'b1) bad++;
        end
        check("idle 100 cycles bad samples", bad, 0);

        // Single frames: acceptance at E0, tx still high after E0, start bit from E1.
        for (int i = 0; i < 7; i++) begin
            baud_div = 16'(vecs[i].div);
            drive_write(vecs[i].data, vecs[i].par);
            check($sformatf("vec%0d tx high after accept", i), tx, 1);
            check($sformatf("vec%0d busy before pop", i), tx_busy, 0);
            @(negedge clk);
            check($sformatf("vec%0d busy at start", i), tx_busy, 1);
            receive_frame(vecs[i].div, $sformatf("vec%0d", i));
            check($sformatf("vec%0d busy after frame", i), tx_busy, 0);
            check($sformatf("vec%0d tx idle after frame", i), tx, 1);
        end

        // baud_div change mid-frame must not affect the frame already started.
        baud_div = 16'd3;
        drive_write(8'h3C, 1'b0);
        @(negedge clk);
        baud_div = 16'd7;
        receive_frame(3, "div change");
        check("div change busy after", tx_busy, 0);

        // Three writes on consecutive cycles give three contiguous frames.
        baud_div = 16'd233;
        fork
            begin
                drive_write(8'h41, 1'b0);
                drive_write(8'h42, 1'b0);
                drive_write(8'h43, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                receive_frame(233, "burst0");
                receive_frame(233, "burst1");
                receive_frame(233, "burst2");
            end
        join
        check("burst busy after", tx_busy, 0);
        check("burst scoreboard drained", sb_q.size(), 0);

        // Hold wr_valid for 20 cycles: 17 accepted, FIFO full; a write during the pop while full is refused.
        baud_div = 16'd1000;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            if (wr_ready) accepted++;
            @(negedge clk);
        end
        check("fill accepted", accepted, 17);
        check("fill wr_ready", wr_ready, 0);
        check("fill fifo_count", fifo_count, DEPTH);
        n = 0;
        while (fifo_count == 5'(DEPTH) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        wr_valid = 1'b0;
        check("fill count after first frame", fifo_count, 15);
        check("fill cycles to first pop", n, 9992);
        check("fill next start bit", tx, 0);
        apply_reset();

        // Reset in data bit 3 with 5 bytes queued.
        baud_div = 16'd3;
        drive_write(8'hF0, 1'b0);
        drive_write(8'h11, 1'b0);
        drive_write(8'h22, 1'b0);
        drive_write(8'h33, 1'b0);
        drive_write(8'h44, 1'b0);
        drive_write(8'h55, 1'b0);
        repeat (13) @(negedge clk);
        check("prereset fifo_count", fifo_count, 5);
        check("prereset tx in bit3", tx, 0);
        #2 rst = 1'b1;
        #1;
        check("async reset tx", tx, 1);
        check("async reset fifo_count", fifo_count, 0);
        check("async reset tx_busy", tx_busy, 0);
        check("async reset wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0) bad++;
        end
        check("post reset idle bad samples", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
